// File: rtl/core_pkg.sv
// Shared core definitions: default widths, HLT opcode fields and phase bit indices.
package core_pkg;

   localparam int PC_WIDTH_DEF = 16;
   localparam int INSTR_W      = 16;

   localparam logic [1:0] OP_ARITH = 2'b11;
   localparam logic [3:0] OP3_HLT  = 4'b1111;

   localparam int P1 = 0;
   localparam int P2 = 1;
   localparam int P3 = 2;
   localparam int P4 = 3;
   localparam int P5 = 4;

   function automatic logic is_hlt(input logic [INSTR_W-1:0] instr);
      return (instr[15:14] == OP_ARITH) && (instr[7:4] == OP3_HLT);
   endfunction

endpackage

// File: rtl/fetch_unit_hlt_detect.sv
// Combinational HLT decode of an instruction word; shared with the decoder.
module hlt_detect
   import core_pkg::*;
(
   input  logic [INSTR_W-1:0] instr_i,
   output logic               is_hlt_o
);

   assign is_hlt_o = is_hlt(instr_i);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns PC and IR, squashes the overlapped fetch on a
// taken branch and raises halt when a live HLT sits in IR during p2.
module fetch_unit
   import core_pkg::*;
#(
   parameter int                  PC_WIDTH = PC_WIDTH_DEF,
   parameter logic [PC_WIDTH-1:0] RESET_PC = {PC_WIDTH{1'b0}}
)
(
   input  logic                clock,
   input  logic                reset,
   input  logic [4:0]          phase,
   output logic [PC_WIDTH-1:0] imem_addr,
   input  logic [INSTR_W-1:0]  imem_rdata,
   input  logic                br_taken,
   input  logic [PC_WIDTH-1:0] br_target,
   output logic [PC_WIDTH-1:0] pc,
   output logic [INSTR_W-1:0]  ir,
   output logic [PC_WIDTH-1:0] ir_pc,
   output logic                ir_valid,
   output logic                halt
);

   logic [PC_WIDTH-1:0] pc_q, pc_d;
   logic [INSTR_W-1:0]  ir_q, ir_d;
   logic [PC_WIDTH-1:0] ir_pc_q, ir_pc_d;
   logic                ir_valid_q, ir_valid_d;
   logic                is_hlt_s;
   logic                unused_phase_s;

   // p3/p4 carry no work for this stage
   assign unused_phase_s = phase[P3] ^ phase[P4];

   hlt_detect u_hlt_detect (
      .instr_i  (ir_q),
      .is_hlt_o (is_hlt_s)
   );

   // Next-state: a taken branch at p5 overrides any fetch in the same cycle
   always_comb begin
      pc_d       = pc_q;
      ir_d       = ir_q;
      ir_pc_d    = ir_pc_q;
      ir_valid_d = ir_valid_q;
      if (phase[P5] && br_taken) begin
         pc_d       = br_target;
         ir_valid_d = 1'b0;
      end else if (phase[P1] && !phase[P5]) begin
         ir_d       = imem_rdata;
         ir_pc_d    = pc_q;
         pc_d       = pc_q + {{(PC_WIDTH-1){1'b0}}, 1'b1};
         ir_valid_d = 1'b1;
      end else begin
         ir_valid_d = ir_valid_q;
      end
   end

   // State registers with asynchronous active-low reset
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pc_q       <= RESET_PC;
         ir_q       <= {INSTR_W{1'b0}};
         ir_pc_q    <= {PC_WIDTH{1'b0}};
         ir_valid_q <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         ir_q       <= ir_d;
         ir_pc_q    <= ir_pc_d;
         ir_valid_q <= ir_valid_d;
      end
   end

   assign imem_addr = pc_q;
   assign pc        = pc_q;
   assign ir        = ir_q;
   assign ir_pc     = ir_pc_q;
   assign ir_valid  = ir_valid_q;
   // Zero-latency so the phase counter can stop at the end of this p2 cycle
   assign halt      = ir_valid_q & is_hlt_s & phase[P2];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed plus randomized bench for fetch_unit against a behavioural model.
module tb_fetch_unit;

   logic        clock;
   logic        reset;
   logic [4:0]  phase;
   logic [15:0] imem_addr;
   logic [15:0] imem_rdata;
   logic        br_taken;
   logic [15:0] br_target;
   logic [15:0] pc;
   logic [15:0] ir;
   logic [15:0] ir_pc;
   logic        ir_valid;
   logic        halt;

   logic [15:0] mem [0:255];
   logic [15:0] m_pc, m_ir, m_irpc;
   logic        m_valid;
   int          n_checks;
   int          n_err;

   fetch_unit #(.PC_WIDTH(16), .RESET_PC(16'h0000)) dut (
      .clock      (clock),
      .reset      (reset),
      .phase      (phase),
      .imem_addr  (imem_addr),
      .imem_rdata (imem_rdata),
      .br_taken   (br_taken),
      .br_target  (br_target),
      .pc         (pc),
      .ir         (ir),
      .ir_pc      (ir_pc),
      .ir_valid   (ir_valid),
      .halt       (halt)
   );

   assign imem_rdata = mem[imem_addr[7:0]];

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic exp_halt(input logic [4:0] ph);
      return m_valid && (m_ir[15:14] == 2'b11) && (m_ir[7:4] == 4'hF) && ph[1];
   endfunction

   task automatic check_all(input string tag);
      chk({tag, ".pc"}, {16'd0, pc}, {16'd0, m_pc});
      chk({tag, ".imem_addr"}, {16'd0, imem_addr}, {16'd0, m_pc});
      chk({tag, ".ir"}, {16'd0, ir}, {16'd0, m_ir});
      chk({tag, ".ir_pc"}, {16'd0, ir_pc}, {16'd0, m_irpc});
      chk({tag, ".ir_valid"}, {31'd0, ir_valid}, {31'd0, m_valid});
   endtask

   // One cycle: drive at negedge, check halt before the edge, update model, check after
   task automatic cyc(input logic [4:0] ph, input logic bt, input logic [15:0] tg);
      logic [15:0] word;
      phase     = ph;
      br_taken  = bt;
      br_target = tg;
      #1;
      chk("halt", {31'd0, halt}, {31'd0, exp_halt(ph)});
      word = mem[m_pc[7:0]];
      @(posedge clock);
      if (ph[4] && bt) begin
         m_pc    = tg;
         m_valid = 1'b0;
      end else if (ph[0] && !ph[4]) begin
         m_ir    = word;
         m_irpc  = m_pc;
         m_pc    = m_pc + 16'd1;
         m_valid = 1'b1;
      end
      #1;
      check_all("step");
      @(negedge clock);
   endtask

   task automatic model_reset();
      m_pc    = 16'h0000;
      m_ir    = 16'h0000;
      m_irpc  = 16'h0000;
      m_valid = 1'b0;
   endtask

   initial begin
      n_checks  = 0;
      n_err     = 0;
      for (int i = 0; i < 256; i++) begin
         mem[i] = 16'($urandom);
         if ((i % 8) == 3) mem[i] = 16'hC0F0 | 16'($urandom_range(0, 15));
      end
      mem[8'h00] = 16'hA5A5;
      mem[8'h01] = 16'h1234;
      mem[8'h40] = 16'h5A5A;
      mem[8'h41] = 16'h0F0F;
      mem[8'hFF] = 16'h2468;
      mem[8'h20] = 16'hC0F0;
      phase     = 5'b00000;
      br_taken  = 1'b0;
      br_target = 16'h0000;
      reset     = 1'b0;
      model_reset();
      @(negedge clock);
      @(negedge clock);
      check_all("reset");
      chk("reset.halt", {31'd0, halt}, 32'd0);
      reset = 1'b1;
      @(negedge clock);

      // First fetch from 0
      cyc(5'b00001, 1'b0, 16'h0000);
      chk("fetch0.ir", {16'd0, ir}, 32'h0000A5A5);
      chk("fetch0.pc", {16'd0, pc}, 32'h00000001);
      chk("fetch0.valid", {31'd0, ir_valid}, 32'd1);

      // Overlapped run with taken branch to 0x0040
      cyc(5'b00010, 1'b0, 16'h0000);
      cyc(5'b00101, 1'b0, 16'h0000);
      cyc(5'b01000, 1'b0, 16'h0000);
      cyc(5'b10010, 1'b1, 16'h0040);
      chk("br.valid", {31'd0, ir_valid}, 32'd0);
      chk("br.pc", {16'd0, pc}, 32'h00000040);
      cyc(5'b00101, 1'b0, 16'h0000);
      chk("br.ir_pc", {16'd0, ir_pc}, 32'h00000040);
      chk("br.ir", {16'd0, ir}, 32'h00005A5A);
      cyc(5'b01000, 1'b0, 16'h0000);
      cyc(5'b10010, 1'b0, 16'h1111);
      chk("nt.pc", {16'd0, pc}, 32'h00000041);

      // PC wrap
      cyc(5'b10000, 1'b1, 16'hFFFF);
      cyc(5'b00001, 1'b0, 16'h0000);
      chk("wrap.pc", {16'd0, pc}, 32'h00000000);
      chk("wrap.ir_pc", {16'd0, ir_pc}, 32'h0000FFFF);

      // HLT live, then squashed
      cyc(5'b10000, 1'b1, 16'h0020);
      cyc(5'b00001, 1'b0, 16'h0000);
      phase = 5'b00010;
      #1;
      chk("hlt.live", {31'd0, halt}, 32'd1);
      cyc(5'b00010, 1'b0, 16'h0000);
      cyc(5'b10000, 1'b1, 16'h0030);
      phase = 5'b00010;
      #1;
      chk("hlt.squashed", {31'd0, halt}, 32'd0);
      cyc(5'b00010, 1'b0, 16'h0000);
      cyc(5'b00000, 1'b1, 16'h7777);
      chk("stop.pc", {16'd0, pc}, 32'h00000030);

      // Simultaneous p1+p5 taken branch
      cyc(5'b00001, 1'b0, 16'h0000);
      cyc(5'b10001, 1'b1, 16'h0010);
      chk("p1p5.pc", {16'd0, pc}, 32'h00000010);
      chk("p1p5.ir_pc", {16'd0, ir_pc}, 32'h00000030);
      chk("p1p5.valid", {31'd0, ir_valid}, 32'd0);

      // Asynchronous reset mid-cycle in 01000 with pc=0x0123
      cyc(5'b10000, 1'b1, 16'h0123);
      cyc(5'b00001, 1'b0, 16'h0000);
      cyc(5'b10000, 1'b1, 16'h0123);
      phase    = 5'b01000;
      br_taken = 1'b0;
      #2;
      chk("pre_arst.pc", {16'd0, pc}, 32'h00000123);
      reset = 1'b0;
      model_reset();
      #1;
      check_all("arst");
      chk("arst.halt", {31'd0, halt}, 32'd0);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);

      // Randomized phase/branch traffic
      for (int k = 0; k < 400; k++) begin
         logic [4:0] rph;
         case ($urandom_range(0, 5))
            0: rph = 5'b00001;
            1: rph = 5'b00010;
            2: rph = 5'b00101;
            3: rph = 5'b10010;
            4: rph = 5'b00000;
            default: rph = 5'($urandom);
         endcase
         cyc(rph, 1'($urandom_range(0, 2) == 0), 16'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
